// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command master.
//  - FSM state encodings (legacy-compatible localparams).
//  - CPLD opcode constants and mk_cmd() to build a command word.
package spi_cmd_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [2:0] OP_SEL = 3'd0;
  localparam logic [2:0] OP_DIR = 3'd1;
  localparam logic [2:0] OP_DIV = 3'd2;
  localparam logic [2:0] OP_ENA = 3'd3;
  localparam logic [2:0] OP_POS = 3'd4;

  function automatic logic [15:0] mk_cmd(input logic [2:0] op, input logic [12:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// Command/response bus between the host bridge and spi_cmd_master.
//  cmd_valid/cmd_data/cmd_ready : command handshake (host -> block)
//  rsp_valid/rsp_data           : one-cycle response strobe and captured word
//  busy                         : transaction in progress
// Modports: master = host side, slave = spi_cmd_master.
interface spi_cmd_master_if;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period counter and SCK register.
//  CLK, reset : system clock, async active-high reset
//  en         : run the generator (SHIFT state only); counter parks at 0 otherwise
//  sck        : registered serial clock, idle low
//  rise/fall  : high in the cycle whose closing edge drives SCK high/low
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic CLK,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            sck_q;
  logic            wrap;

  assign wrap = en && (cnt_q == CntMax);
  assign rise = wrap && !sck_q;
  assign fall = wrap && sck_q;
  assign sck  = sck_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CntW'(1);
      if (wrap) sck_q <= !sck_q;
    end
  end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI master (mode 0, MSB first, 16-bit words) for the motor-controller CPLD command port.
//  CLK, reset : system clock, async active-high reset
//  bus        : command/response interface (slave modport)
//  SCK, MOSI  : serial clock (idle low) and data out
//  MISO       : serial data in, used unsynchronised (stable CLK_DIV cycles before sampling)
//  SSEL       : slave select, active low
// The CPLD loads its reply on word receipt, so rsp_data answers the previous command.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 16
) (
  input  logic                    CLK,
  input  logic                    reset,
  spi_cmd_master_if.slave         bus,
  output logic                    SCK,
  output logic                    MOSI,
  input  logic                    MISO,
  output logic                    SSEL
);

  localparam int unsigned TmrW = $clog2(SETUP_CYCLES + CLK_DIV + GAP_CYCLES + 1);

  logic [2:0]      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     tx_sr_q, tx_sr_d;
  logic [15:0]     rx_sr_q, rx_sr_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            mosi_q, mosi_d;
  logic            ssel_q, ssel_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            sck_rise, sck_fall;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .CLK   (CLK),
    .reset (reset),
    .en    (state_q == ST_SHIFT),
    .sck   (SCK),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rsp_data_d  = rsp_data_q;
    mosi_d      = mosi_q;
    ssel_d      = ssel_q;
    busy_d      = busy_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        // Accept only against the registered ready the host actually saw.
        if (bus.cmd_valid && ready_q) begin
          tx_sr_d   = bus.cmd_data;
          mosi_d    = bus.cmd_data[15];
          bit_cnt_d = 4'd15;
          busy_d    = 1'b1;
          ssel_d    = 1'b0;
          ready_d   = 1'b0;
          tmr_d     = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_q == TmrW'(SETUP_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      ST_SHIFT: begin
        if (sck_rise) rx_sr_d = {rx_sr_q[14:0], MISO};
        if (sck_fall) begin
          if (bit_cnt_q == 4'd0) begin
            tmr_d   = '0;
            state_d = ST_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            tx_sr_d   = {tx_sr_q[14:0], 1'b0};
            mosi_d    = tx_sr_q[14];
          end
        end
      end
      ST_HOLD: begin
        if (tmr_q == TmrW'(CLK_DIV - 1)) begin
          ssel_d      = 1'b1;
          rsp_data_d  = rx_sr_q;
          rsp_valid_d = 1'b1;
          tmr_d       = '0;
          state_d     = ST_GAP;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == TmrW'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rsp_data_q  <= '0;
      mosi_q      <= 1'b0;
      ssel_q      <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rsp_data_q  <= rsp_data_d;
      mosi_q      <= mosi_d;
      ssel_q      <= ssel_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign MOSI          = mosi_q;
  assign SSEL          = ssel_q;
  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
